// File: rtl/gpu_sched_pkg.sv
// rtl/gpu_sched_pkg.sv - shared field positions, slot type and decode helpers for the warp issue scheduler
package gpu_sched_pkg;

  localparam int REG_W    = 5;
  localparam int OP_LSB   = 27;
  localparam int DST_LSB  = 22;
  localparam int SRC1_LSB = 17;
  localparam int SRC2_LSB = 12;

  // Ops at or above this value are stores/branches and never reserve a destination.
  localparam logic [4:0] OP_NOWRITE_BASE = 5'h18;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } warp_slot_t;

  function automatic logic [4:0] op_of(input logic [31:0] instr);
    return instr[OP_LSB +: 5];
  endfunction

  function automatic logic [REG_W-1:0] dst_of(input logic [31:0] instr);
    return instr[DST_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] src1_of(input logic [31:0] instr);
    return instr[SRC1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] src2_of(input logic [31:0] instr);
    return instr[SRC2_LSB +: REG_W];
  endfunction

  function automatic logic is_writing(input logic [31:0] instr);
    return op_of(instr) < OP_NOWRITE_BASE;
  endfunction

endpackage

// File: rtl/warp_scoreboard.sv
// rtl/warp_scoreboard.sv - per-warp pending-write bits with set/clear ports and three-register hazard query
module warp_scoreboard
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 32,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [WID_W-1:0]           set_warp,
  input  logic [REG_W-1:0]           set_reg,
  input  logic                       clr_en,
  input  logic [WID_W-1:0]           clr_warp,
  input  logic [REG_W-1:0]           clr_reg,
  input  logic [NUM_WARPS*REG_W-1:0] q_dst,
  input  logic [NUM_WARPS*REG_W-1:0] q_src1,
  input  logic [NUM_WARPS*REG_W-1:0] q_src2,
  output logic [NUM_WARPS-1:0]       hazard,
  output logic                       any_pending
);

  logic [NUM_REGS-1:0] pend [NUM_WARPS];

  // Pending bits: the set is written after the clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) pend[w] <= '0;
    end else begin
      if (clr_en) pend[clr_warp][clr_reg] <= 1'b0;
      if (set_en) pend[set_warp][set_reg] <= 1'b1;
    end
  end

  // Hazard per warp when any of its slot's three registers awaits writeback.
  always_comb begin
    hazard      = '0;
    any_pending = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      hazard[w] = pend[w][q_dst[w*REG_W +: REG_W]]
                | pend[w][q_src1[w*REG_W +: REG_W]]
                | pend[w][q_src2[w*REG_W +: REG_W]];
      any_pending = any_pending | (|pend[w]);
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// rtl/warp_issue_scheduler.sv - per-warp instruction slots, scoreboard and priority/round-robin issue arbiter (optional SCHED_PRIORITY_AGING_EN)
module warp_issue_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int  NUM_WARPS = 8,
  parameter int  NUM_REGS  = 32,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_WARPS-1:0]   warp_enable,
  input  logic [NUM_WARPS*4-1:0] warp_priority,
  input  logic                   fetch_valid,
  input  logic [WID_W-1:0]       fetch_warp,
  input  logic [31:0]            fetch_instr,
  output logic                   fetch_ready,
  output logic                   issue_valid,
  output logic [WID_W-1:0]       issue_warp,
  output logic [31:0]            issue_instr,
  input  logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [WID_W-1:0]       wb_warp,
  input  logic [4:0]             wb_reg,
  output logic                   busy,
  output logic [31:0]            issue_count,
  output logic [31:0]            stall_cycles
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  warp_slot_t                 slot [NUM_WARPS];
  logic [WID_W-1:0]           rr_ptr;
  logic [NUM_WARPS-1:0]       slot_valid;
  logic [NUM_WARPS-1:0]       hazard;
  logic [NUM_WARPS-1:0]       elig;
  logic [NUM_WARPS*REG_W-1:0] q_dst;
  logic [NUM_WARPS*REG_W-1:0] q_src1;
  logic [NUM_WARPS*REG_W-1:0] q_src2;
  logic [4:0]                 sel_key [NUM_WARPS];
  logic [4:0]                 best_key;
  logic [WID_W-1:0]           scan_idx;
  logic [WID_W-1:0]           win;
  logic                       win_found;
  logic                       load;
  logic                       any_pending;
  logic                       set_en;
`ifdef SCHED_PRIORITY_AGING_EN
  logic [3:0]                 age [NUM_WARPS];
`endif

  assign fetch_ready = !slot[fetch_warp].valid;
  assign load        = !issue_valid || issue_ready;
  assign elig        = slot_valid & warp_enable & ~hazard;
  assign set_en      = load && win_found && is_writing(slot[win].instr);
  assign busy        = (|slot_valid) || issue_valid || any_pending;

  // Unpack slot register fields for the scoreboard and form each warp's arbitration key.
  always_comb begin
    slot_valid = '0;
    q_dst      = '0;
    q_src1     = '0;
    q_src2     = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      slot_valid[w]              = slot[w].valid;
      q_dst[w*REG_W +: REG_W]    = dst_of(slot[w].instr);
      q_src1[w*REG_W +: REG_W]   = src1_of(slot[w].instr);
      q_src2[w*REG_W +: REG_W]   = src2_of(slot[w].instr);
`ifdef SCHED_PRIORITY_AGING_EN
      // A fully aged warp outranks every priority; all aged warps tie and fall to RR.
      sel_key[w] = (age[w] == 4'hF) ? 5'h10 : {1'b0, warp_priority[w*4 +: 4]};
`else
      sel_key[w] = {1'b0, warp_priority[w*4 +: 4]};
`endif
    end
  end

  // Scan from rr_ptr upward; only a strictly larger key replaces the pick, so ties keep RR order.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    best_key  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_ptr + WID_W'(i);
      if (elig[scan_idx] && (!win_found || (sel_key[scan_idx] > best_key))) begin
        win_found = 1'b1;
        win       = scan_idx;
        best_key  = sel_key[scan_idx];
      end
    end
  end

  // Slot capture, issue register load and round-robin pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) slot[w] <= '0;
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      issue_warp  <= '0;
      issue_instr <= '0;
    end else begin
      if (fetch_valid && fetch_ready) slot[fetch_warp] <= '{valid: 1'b1, instr: fetch_instr};
      if (load) begin
        if (win_found) begin
          issue_valid <= 1'b1;
          issue_warp  <= win;
          issue_instr <= slot[win].instr;
          slot[win]   <= '0;
          rr_ptr      <= win + 1'b1;
        end else begin
          issue_valid <= 1'b0;
        end
      end
    end
  end

  // Saturating counters for accepted issues and hazard-stalled load cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (issue_valid && issue_ready && issue_count != CNT_MAX) issue_count <= issue_count + 32'd1;
      if (load && (|(slot_valid & warp_enable)) && !win_found && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

`ifdef SCHED_PRIORITY_AGING_EN
  // Eligible losers of a load cycle age by one (saturating); the winner restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) age[w] <= '0;
    end else if (load && win_found) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (WID_W'(w) == win) age[w] <= '0;
        else if (elig[w] && age[w] != 4'hF) age[w] <= age[w] + 4'd1;
      end
    end
  end
`endif

  warp_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS),
    .WID_W     (WID_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en      (set_en),
    .set_warp    (win),
    .set_reg     (dst_of(slot[win].instr)),
    .clr_en      (wb_valid),
    .clr_warp    (wb_warp),
    .clr_reg     (wb_reg),
    .q_dst       (q_dst),
    .q_src1      (q_src1),
    .q_src2      (q_src2),
    .hazard      (hazard),
    .any_pending (any_pending)
  );

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb/tb_warp_issue_scheduler.sv - self-checking bench for warp_issue_scheduler
module tb_warp_issue_scheduler;

  localparam int NW = 8;
  localparam int WW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NW-1:0]   warp_enable;
  logic [NW*4-1:0] warp_priority;
  logic            fetch_valid;
  logic [WW-1:0]   fetch_warp;
  logic [31:0]     fetch_instr;
  logic            fetch_ready;
  logic            issue_valid;
  logic [WW-1:0]   issue_warp;
  logic [31:0]     issue_instr;
  logic            issue_ready;
  logic            wb_valid;
  logic [WW-1:0]   wb_warp;
  logic [4:0]      wb_reg;
  logic            busy;
  logic [31:0]     issue_count;
  logic [31:0]     stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  warp_issue_scheduler #(.NUM_WARPS(NW), .NUM_REGS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .warp_enable   (warp_enable),
    .warp_priority (warp_priority),
    .fetch_valid   (fetch_valid),
    .fetch_warp    (fetch_warp),
    .fetch_instr   (fetch_instr),
    .fetch_ready   (fetch_ready),
    .issue_valid   (issue_valid),
    .issue_warp    (issue_warp),
    .issue_instr   (issue_instr),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_warp       (wb_warp),
    .wb_reg        (wb_reg),
    .busy          (busy),
    .issue_count   (issue_count),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] dst,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {op, dst, s1, s2, 12'h000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0;
    fetch_warp  = '0;
    fetch_instr = '0;
    wb_valid    = 1'b0;
    wb_warp     = '0;
    wb_reg      = '0;
  endtask

  task automatic do_reset();
    idle();
    issue_ready   = 1'b1;
    warp_enable   = '1;
    warp_priority = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [WW-1:0] w, input logic [31:0] ins);
    fetch_valid = 1'b1;
    fetch_warp  = w;
    fetch_instr = ins;
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NW];
  logic [31:0] m_instr [NW];
  bit   [31:0] m_pend  [NW];
  int          m_age   [NW];
  int          m_rr;
  bit          m_iv;
  int          m_iw;
  logic [31:0] m_ii;
  int unsigned m_cnt;
  int unsigned m_stall;

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_valid[w] = 0; m_instr[w] = '0; m_pend[w] = '0; m_age[w] = 0;
    end
    m_rr = 0; m_iv = 0; m_iw = 0; m_ii = '0; m_cnt = 0; m_stall = 0;
  endtask

  task automatic model_compare(input int c);
    bit any_busy;
    any_busy = m_iv;
    for (int w = 0; w < NW; w++) any_busy = any_busy || m_valid[w] || (m_pend[w] != 0);
    chk($sformatf("rnd_fetch_ready@%0d", c), {31'd0, fetch_ready}, {31'd0, !m_valid[fetch_warp]});
    chk($sformatf("rnd_issue_valid@%0d", c), {31'd0, issue_valid}, {31'd0, m_iv});
    if (m_iv) begin
      chk($sformatf("rnd_issue_warp@%0d", c), {29'd0, issue_warp}, m_iw);
      chk($sformatf("rnd_issue_instr@%0d", c), issue_instr, m_ii);
    end
    chk($sformatf("rnd_busy@%0d", c), {31'd0, busy}, {31'd0, any_busy});
    chk($sformatf("rnd_issue_count@%0d", c), issue_count, m_cnt);
    chk($sformatf("rnd_stall@%0d", c), stall_cycles, m_stall);
  endtask

  task automatic model_step();
    bit load, found, any_en_valid;
    bit elig [NW];
    int win, best, key, w;
    load = !m_iv || issue_ready;
    found = 0; best = -1; win = 0; any_en_valid = 0;
    for (int k = 0; k < NW; k++) begin
      int d, s1, s2;
      d  = m_instr[k][26:22];
      s1 = m_instr[k][21:17];
      s2 = m_instr[k][16:12];
      any_en_valid = any_en_valid || (m_valid[k] && warp_enable[k]);
      elig[k] = m_valid[k] && warp_enable[k] && !m_pend[k][d] && !m_pend[k][s1] && !m_pend[k][s2];
    end
    for (int k = 0; k < NW; k++) begin
      w = (m_rr + k) % NW;
      key = warp_priority[w*4 +: 4];
`ifdef SCHED_PRIORITY_AGING_EN
      if (m_age[w] == 15) key = 16;
`endif
      if (elig[w] && key > best) begin
        best = key; win = w; found = 1;
      end
    end
    if (m_iv && issue_ready && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (load && any_en_valid && !found && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (wb_valid) m_pend[wb_warp][wb_reg] = 1'b0;
    if (fetch_valid && !m_valid[fetch_warp]) begin
      m_valid[fetch_warp] = 1;
      m_instr[fetch_warp] = fetch_instr;
    end
    if (load) begin
      if (found) begin
        m_iv = 1; m_iw = win; m_ii = m_instr[win];
        m_valid[win] = 0;
        m_rr = (win + 1) % NW;
        if (m_ii[31:27] < 5'h18) m_pend[win][m_ii[26:22]] = 1'b1;
      end else begin
        m_iv = 0;
      end
    end
`ifdef SCHED_PRIORITY_AGING_EN
    if (load && found) begin
      for (int k = 0; k < NW; k++) begin
        if (k == win) m_age[k] = 0;
        else if (elig[k] && m_age[k] < 15) m_age[k]++;
      end
    end
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WW-1:0] warp;
    logic [31:0]   instr;
    logic [31:0]   exp_count;
    logic [31:0]   exp_stall;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic order_run(input logic [NW*4-1:0] pri, input int e0, input int e1, input int e2,
                           input string tag);
    warp_priority = pri;
    warp_enable   = '0;
    fetch(0, mk(5'h18, 0, 0, 0)); tick();
    fetch(1, mk(5'h19, 0, 0, 0)); tick();
    fetch(3, mk(5'h1A, 0, 0, 0)); tick();
    fetch_valid = 1'b0;
    warp_enable = '1;
    tick(); chk({tag, "_first"},  {29'd0, issue_warp}, e0); chk({tag, "_first_v"}, {31'd0, issue_valid}, 1);
    tick(); chk({tag, "_second"}, {29'd0, issue_warp}, e1);
    tick(); chk({tag, "_third"},  {29'd0, issue_warp}, e2);
  endtask

`ifdef SCHED_PRIORITY_AGING_EN
  int loads;
  bit aged_found;
`endif

  initial begin
    vecs[0] = '{3'd2, mk(5'h00,  5, 1, 2), 32'd1, 32'd2, 1'b1};
    vecs[1] = '{3'd0, mk(5'h17, 31, 3, 4), 32'd1, 32'd2, 1'b1};
    vecs[2] = '{3'd7, mk(5'h18,  7, 0, 0), 32'd2, 32'd0, 1'b0};
    vecs[3] = '{3'd5, mk(5'h1F,  9, 1, 1), 32'd2, 32'd0, 1'b0};
    vecs[4] = '{3'd3, mk(5'h10,  0, 1, 1), 32'd1, 32'd2, 1'b1};
    vecs[5] = '{3'd1, mk(5'h1C, 12, 2, 3), 32'd2, 32'd0, 1'b0};

    // Reset state
    idle();
    issue_ready = 1'b1; warp_enable = '1; warp_priority = '0;
    rst = 1'b1;
    #1;
    chk("reset_issue_valid", {31'd0, issue_valid}, 0);
    chk("reset_issue_instr", issue_instr, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_count", issue_count, 0);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_fetch_ready", {31'd0, fetch_ready}, 1);

    // Table: latency, issue contents, and whether the op reserves its destination
    for (int i = 0; i < 6; i++) begin
      do_reset();
      fetch(vecs[i].warp, vecs[i].instr);
      tick();
      fetch_valid = 1'b0;
      chk($sformatf("vec%0d_not_yet", i), {31'd0, issue_valid}, 0);
      chk($sformatf("vec%0d_slot_full", i), {31'd0, fetch_ready}, 0);
      tick();
      chk($sformatf("vec%0d_issue_valid", i), {31'd0, issue_valid}, 1);
      chk($sformatf("vec%0d_issue_warp", i), {29'd0, issue_warp}, {29'd0, vecs[i].warp});
      chk($sformatf("vec%0d_issue_instr", i), issue_instr, vecs[i].instr);
      fetch(vecs[i].warp, mk(5'h18, vecs[i].instr[26:22], vecs[i].instr[26:22], vecs[i].instr[26:22]));
      tick();
      fetch_valid = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d_count", i), issue_count, vecs[i].exp_count);
      chk($sformatf("vec%0d_stall", i), stall_cycles, vecs[i].exp_stall);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end

    // RAW stall released by writeback: issue two cycles after wb
    do_reset();
    fetch(2, mk(5'h00, 5, 1, 2)); tick();
    fetch_valid = 1'b0; tick();
    chk("raw_first_warp", {29'd0, issue_warp}, 2);
    chk("raw_busy", {31'd0, busy}, 1);
    fetch(2, mk(5'h01, 6, 5, 3)); tick();
    fetch_valid = 1'b0; tick(); tick();
    chk("raw_stall2", stall_cycles, 2);
    chk("raw_blocked", {31'd0, issue_valid}, 0);
    wb_valid = 1'b1; wb_warp = 2; wb_reg = 5;
    tick();
    wb_valid = 1'b0;
    chk("raw_wb_edge_iv", {31'd0, issue_valid}, 0);
    chk("raw_wb_edge_stall", stall_cycles, 3);
    tick();
    chk("raw_release_iv", {31'd0, issue_valid}, 1);
    chk("raw_release_warp", {29'd0, issue_warp}, 2);
    chk("raw_release_instr", issue_instr, mk(5'h01, 6, 5, 3));
    chk("raw_release_stall", stall_cycles, 3);

    // Priority then round-robin ordering
    do_reset();
    order_run(32'h0000_9094, 1, 3, 0, "prio");
    chk("prio_no_stall_when_disabled", stall_cycles, 0);
    fetch(1, mk(5'h18, 0, 0, 0)); tick();
    fetch_valid = 1'b0; tick();
    chk("rr_setup_warp", {29'd0, issue_warp}, 1);
    order_run(32'h7777_7777, 3, 0, 1, "rr");

    // Backpressure holds the issue register
    do_reset();
    issue_ready = 1'b0;
    fetch(5, mk(5'h02, 10, 11, 12)); tick();
    fetch(6, mk(5'h03, 13, 14, 15)); tick();
    fetch_valid = 1'b0;
    chk("bp_first_warp", {29'd0, issue_warp}, 5);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", k), {31'd0, issue_valid}, 1);
      chk($sformatf("bp_hold_warp%0d", k), {29'd0, issue_warp}, 5);
      chk($sformatf("bp_hold_instr%0d", k), issue_instr, mk(5'h02, 10, 11, 12));
      chk($sformatf("bp_hold_count%0d", k), issue_count, 0);
    end
    chk("bp_no_stall", stall_cycles, 0);
    issue_ready = 1'b1;
    tick();
    chk("bp_release_count", issue_count, 1);
    chk("bp_next_warp", {29'd0, issue_warp}, 6);

    // Same-cycle set and clear: set wins; later clear drains busy
    do_reset();
    fetch(4, mk(5'h02, 6, 0, 0)); tick();
    fetch_valid = 1'b0;
    wb_valid = 1'b1; wb_warp = 4; wb_reg = 6;
    tick();
    wb_valid = 1'b0;
    chk("sc_issue_warp", {29'd0, issue_warp}, 4);
    tick();
    chk("sc_issue_drained", {31'd0, issue_valid}, 0);
    chk("sc_set_wins_busy", {31'd0, busy}, 1);
    wb_valid = 1'b1; wb_warp = 4; wb_reg = 9;
    tick();
    chk("sc_stray_clear_busy", {31'd0, busy}, 1);
    wb_reg = 6;
    tick();
    wb_valid = 1'b0;
    chk("sc_clear_busy", {31'd0, busy}, 0);

    // Asynchronous reset in flight
    do_reset();
    fetch(0, mk(5'h00, 1, 0, 0)); tick();
    fetch(1, mk(5'h00, 2, 0, 0)); tick();
    fetch(2, mk(5'h00, 3, 0, 0)); tick();
    fetch_valid = 1'b0; tick();
    issue_ready = 1'b0; tick();
    chk("ar_pre_valid", {31'd0, issue_valid}, 1);
    chk("ar_pre_count", issue_count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_issue_valid", {31'd0, issue_valid}, 0);
    chk("ar_issue_warp", {29'd0, issue_warp}, 0);
    chk("ar_issue_instr", issue_instr, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_count", issue_count, 0);
    chk("ar_stall", stall_cycles, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef SCHED_PRIORITY_AGING_EN
    // Aging: priority-0 warp against a continuous priority-15 stream
    do_reset();
    warp_priority = 32'h0000_0FF0;
    warp_enable = 8'b0000_0110;
    fetch(0, mk(5'h18, 0, 0, 0)); tick();
    fetch(1, mk(5'h18, 0, 0, 0)); tick();
    fetch(2, mk(5'h18, 0, 0, 0)); tick();
    fetch(1, mk(5'h18, 0, 0, 0)); tick();
    warp_enable = '1;
    loads = 0;
    aged_found = 0;
    for (int c = 0; c < 40 && !aged_found; c++) begin
      if (issue_valid && issue_warp != 0) fetch(issue_warp, mk(5'h18, 0, 0, 0));
      else fetch_valid = 1'b0;
      tick();
      loads++;
      if (issue_valid && issue_warp == 0) aged_found = 1;
    end
    fetch_valid = 1'b0;
    chk("aging_found", {31'd0, aged_found}, 1);
    chk("aging_loads", loads, 16);
`endif

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        bit equal;
        logic [3:0] base;
        equal = ($urandom % 4) == 0;
        base  = 4'($urandom);
        for (int w = 0; w < NW; w++) warp_priority[w*4 +: 4] = equal ? base : 4'($urandom);
      end
      for (int w = 0; w < NW; w++) warp_enable[w] = ($urandom % 8) != 0;
      fetch_valid = ($urandom % 10) < 6;
      fetch_warp  = WW'($urandom);
      fetch_instr = $urandom;
      fetch_instr[26:22] = 5'($urandom_range(0, 7));
      fetch_instr[21:17] = 5'($urandom_range(0, 7));
      fetch_instr[16:12] = 5'($urandom_range(0, 7));
      issue_ready = ($urandom % 10) < 7;
      wb_valid    = ($urandom % 10) < 3;
      wb_warp     = WW'($urandom);
      wb_reg      = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_compare(c);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
